store_drain: RTL and testbench

STORE_DRAIN -- requirements
Module: store_drain

---
 rtl/store_drain_if.sv | 45 ++++
 rtl/store_drain.sv | 171 +++++++++++++++++
 tb/tb_store_drain.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_drain_if.sv
// -----------------------------------------------------------------------------
// store_drain_pkg / store_drain_if
//
// store_drain_pkg : shared types for the store-buffer drain path.
//   cache_access_size_t : BYTE / HALF / WORD access size of a store entry.
//
// store_drain_if  : cache write-request bus between the drain engine and the
//                   data cache.
//   req_valid_o  write request valid            (drain -> cache)
//   req_ready_i  cache accepts the request      (cache -> drain)
//   req_addr_o   word-aligned write address     (drain -> cache)
//   req_data_o   lane-aligned write data        (drain -> cache)
//   req_wmask_o  byte write enables             (drain -> cache)
//   done_i       cache write completed          (cache -> drain)
//   modport master : drain engine side; modport slave : cache side.
// -----------------------------------------------------------------------------
package store_drain_pkg;
  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } cache_access_size_t;
endpackage

interface store_drain_if #(
  parameter int ADDR_SIZE = 32,
  parameter int WORD_SIZE = 32
) ();
  logic                   req_valid_o;
  logic                   req_ready_i;
  logic [ADDR_SIZE-1:0]   req_addr_o;
  logic [WORD_SIZE-1:0]   req_data_o;
  logic [WORD_SIZE/8-1:0] req_wmask_o;
  logic                   done_i;

  modport master (
    output req_valid_o, req_addr_o, req_data_o, req_wmask_o,
    input  req_ready_i, done_i
  );

  modport slave (
    input  req_valid_o, req_addr_o, req_data_o, req_wmask_o,
    output req_ready_i, done_i
  );
endinterface

// File: rtl/store_drain.sv
// -----------------------------------------------------------------------------
// store_drain
//
// Drains the oldest store-buffer entry into the data cache, one store at a
// time. Each entry is popped in IDLE, turned into a word-aligned masked write,
// issued on the cache bus (REQ) and then waited on until the cache reports
// completion (WAIT). Misaligned entries are popped and dropped with a pulse.
//
// Ports:
//   clk_i            sole clock, all state changes on posedge
//   reset_n_i        synchronous active-low reset
//   sb_addr_i        oldest store-buffer entry address
//   sb_data_i        oldest store-buffer entry data
//   sb_size_i        oldest store-buffer entry size
//   sb_empty_i       store buffer empty
//   sb_get_o         pop strobe, one cycle per entry
//   hold_i           block new pops (e.g. a load owns the cache)
//   flush_i          drain request, overrides hold_i
//   cache            store_drain_if.master cache write-request bus
//   busy_o           a store is in flight (state != IDLE)
//   drained_o        idle and store buffer empty
//   misaligned_o     one-cycle pulse when a misaligned entry is dropped
//   drained_count_o  completed cache writes, wraps modulo 2^32
//
// Configuration macro STORE_DRAIN_PERF_EN: when defined the completed-write
// counter is built; otherwise drained_count_o is tied to zero.
// Only WORD_SIZE = 32 is supported.
// -----------------------------------------------------------------------------
module store_drain
  import store_drain_pkg::*;
#(
  parameter int ADDR_SIZE = 32,
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [ADDR_SIZE-1:0] sb_addr_i,
  input  logic [WORD_SIZE-1:0] sb_data_i,
  input  cache_access_size_t   sb_size_i,
  input  logic                 sb_empty_i,
  output logic                 sb_get_o,
  input  logic                 hold_i,
  input  logic                 flush_i,
  store_drain_if.master        cache,
  output logic                 busy_o,
  output logic                 drained_o,
  output logic                 misaligned_o,
  output logic [31:0]          drained_count_o
);

  localparam int MASK_SIZE = WORD_SIZE / 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } state_t;

  state_t                 state;
  logic                   req_valid_q;
  logic [ADDR_SIZE-1:0]   req_addr_q;
  logic [WORD_SIZE-1:0]   req_data_q;
  logic [MASK_SIZE-1:0]   req_wmask_q;

  logic [1:0]             lane;
  logic                   pop;
  logic                   misaligned;
  logic [WORD_SIZE-1:0]   data_nxt;
  logic [MASK_SIZE-1:0]   wmask_nxt;

  assign lane = sb_addr_i[1:0];

  // The pop strobe must accompany the entry it consumes, so it is decoded
  // from the current state and inputs rather than registered. Gating with
  // reset_n_i keeps an entry from being lost while reset is held.
  assign pop = reset_n_i && (state == IDLE) && !sb_empty_i && (!hold_i || flush_i);

  // Any size that is not BYTE or HALF is handled as a full word.
  assign misaligned = ((sb_size_i == HALF) && lane[0]) ||
                      ((sb_size_i != BYTE) && (sb_size_i != HALF) && (lane != 2'b00));

  assign sb_get_o     = pop;
  assign misaligned_o = pop && misaligned;

  // Lane placement of the write data and byte enables.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    data_nxt  = sb_data_i;
    wmask_nxt = '1;
    case (sb_size_i)
      BYTE: begin
        wmask_nxt = MASK_SIZE'(1) << lane;
        data_nxt  = WORD_SIZE'(sb_data_i[7:0]) << {lane, 3'b000};
      end
      HALF: begin
        wmask_nxt = MASK_SIZE'(2'b11) << lane;
        data_nxt  = WORD_SIZE'(sb_data_i[15:0]) << {lane, 3'b000};
      end
      default: begin
        wmask_nxt = '1;
        data_nxt  = sb_data_i;
      end
    endcase
  end

  // Drain FSM with registered request outputs; they hold steady in REQ
  // until the cache accepts.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample pre-edge values regardless of statement order.
    if (!reset_n_i) begin
      state       <= IDLE;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_wmask_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop && !misaligned) begin
            req_addr_q  <= {sb_addr_i[ADDR_SIZE-1:2], 2'b00};
            req_data_q  <= data_nxt;
            req_wmask_q <= wmask_nxt;
            req_valid_q <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (cache.req_ready_i) begin
            req_valid_q <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (cache.done_i) state <= IDLE;
        end
        default: begin
          req_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign cache.req_valid_o = req_valid_q;
  assign cache.req_addr_o  = req_addr_q;
  assign cache.req_data_o  = req_data_q;
  assign cache.req_wmask_o = req_wmask_q;

  assign busy_o    = (state != IDLE);
  assign drained_o = (state == IDLE) && sb_empty_i;

`ifdef STORE_DRAIN_PERF_EN
  logic [31:0] drained_count_q;

  // Counts completed cache writes; wraps naturally at 2^32.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      drained_count_q <= '0;
    end else if ((state == WAIT) && cache.done_i) begin
      drained_count_q <= drained_count_q + 32'd1;
    end
  end

  assign drained_count_o = drained_count_q;
`else
  assign drained_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_store_drain.sv
// -----------------------------------------------------------------------------
// tb_store_drain
//
// Directed bench for store_drain: reset state, lane placement for BYTE / HALF /
// WORD, misaligned drop, back-pressure on the request, hold/flush, reset in
// WAIT and back-to-back throughput. Inputs change 1 ns after the rising edge
// and outputs are sampled 2 ns after it.
// -----------------------------------------------------------------------------
module tb_store_drain;
  import store_drain_pkg::*;

`ifdef STORE_DRAIN_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic               clk_i = 1'b0;
  logic               reset_n_i;
  logic [31:0]        sb_addr_i;
  logic [31:0]        sb_data_i;
  cache_access_size_t sb_size_i;
  logic               sb_empty_i;
  logic               sb_get_o;
  logic               hold_i;
  logic               flush_i;
  logic               busy_o;
  logic               drained_o;
  logic               misaligned_o;
  logic [31:0]        drained_count_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  store_drain_if #(.ADDR_SIZE(32), .WORD_SIZE(32)) bus ();

  store_drain #(.ADDR_SIZE(32), .WORD_SIZE(32)) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .sb_addr_i      (sb_addr_i),
    .sb_data_i      (sb_data_i),
    .sb_size_i      (sb_size_i),
    .sb_empty_i     (sb_empty_i),
    .sb_get_o       (sb_get_o),
    .hold_i         (hold_i),
    .flush_i        (flush_i),
    .cache          (bus.master),
    .busy_o         (busy_o),
    .drained_o      (drained_o),
    .misaligned_o   (misaligned_o),
    .drained_count_o(drained_count_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic load(input cache_access_size_t s, input logic [31:0] a, input logic [31:0] d);
    sb_size_i  = s;
    sb_addr_i  = a;
    sb_data_i  = d;
    sb_empty_i = 1'b0;
  endtask

  function automatic logic [31:0] cnt(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  int pop_cyc[$];

  initial begin
    reset_n_i       = 1'b0;
    sb_addr_i       = '0;
    sb_data_i       = '0;
    sb_size_i       = BYTE;
    sb_empty_i      = 1'b1;
    hold_i          = 1'b0;
    flush_i         = 1'b0;
    bus.req_ready_i = 1'b0;
    bus.done_i      = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    #1;
    check("rst_valid",   32'(bus.req_valid_o), 32'd0);
    check("rst_addr",    bus.req_addr_o,       32'd0);
    check("rst_data",    bus.req_data_o,       32'd0);
    check("rst_wmask",   32'(bus.req_wmask_o), 32'd0);
    check("rst_busy",    32'(busy_o),          32'd0);
    check("rst_get",     32'(sb_get_o),        32'd0);
    check("rst_mis",     32'(misaligned_o),    32'd0);
    check("rst_drained", 32'(drained_o),       32'd1);
    check("rst_count",   drained_count_o,      32'd0);

    // ---------------- BYTE 0x1003, immediate ready/done ----------------
    tick();
    reset_n_i       = 1'b1;
    load(BYTE, 32'h0000_1003, 32'h0000_00AB);
    bus.req_ready_i = 1'b1;
    bus.done_i      = 1'b1;   // held high: ignored outside WAIT
    #1;
    check("b_get", 32'(sb_get_o),     32'd1);
    check("b_mis", 32'(misaligned_o), 32'd0);
    tick();
    sb_empty_i = 1'b1;
    #1;
    check("b_valid", 32'(bus.req_valid_o), 32'd1);
    check("b_addr",  bus.req_addr_o,       32'h0000_1000);
    check("b_wmask", 32'(bus.req_wmask_o), 32'h8);
    check("b_data",  bus.req_data_o,       32'hAB00_0000);
    check("b_busy",  32'(busy_o),          32'd1);
    tick();
    #1;
    check("b_wait_valid", 32'(bus.req_valid_o), 32'd0);
    check("b_wait_busy",  32'(busy_o),          32'd1);
    tick();
    #1;
    check("b_idle",    32'(busy_o),     32'd0);
    check("b_drained", 32'(drained_o),  32'd1);
    check("b_count",   drained_count_o, cnt(1));

    // ---------------- HALF 0x2001 misaligned drop ----------------
    bus.req_ready_i = 1'b0;
    bus.done_i      = 1'b0;
    load(HALF, 32'h0000_2001, 32'h0000_BEEF);
    #1;
    check("hm_get", 32'(sb_get_o),     32'd1);
    check("hm_mis", 32'(misaligned_o), 32'd1);
    tick();
    sb_empty_i = 1'b1;
    #1;
    check("hm_mis_end", 32'(misaligned_o),    32'd0);
    check("hm_valid",   32'(bus.req_valid_o), 32'd0);
    check("hm_busy",    32'(busy_o),          32'd0);

    // ---------------- WORD 0x3002 misaligned drop ----------------
    load(WORD, 32'h0000_3002, 32'h0BAD_0BAD);
    #1;
    check("wm_mis", 32'(misaligned_o), 32'd1);
    tick();
    sb_empty_i = 1'b1;
    #1;
    check("wm_valid", 32'(bus.req_valid_o), 32'd0);

    // ---------------- HALF 0x2002 aligned ----------------
    load(HALF, 32'h0000_2002, 32'h1234_CDEF);
    bus.req_ready_i = 1'b1;
    #1;
    check("ha_mis", 32'(misaligned_o), 32'd0);
    tick();
    sb_empty_i = 1'b1;
    #1;
    check("ha_addr",  bus.req_addr_o,       32'h0000_2000);
    check("ha_wmask", 32'(bus.req_wmask_o), 32'hC);
    check("ha_data",  bus.req_data_o,       32'hCDEF_0000);
    tick();
    bus.done_i = 1'b1;
    tick();
    bus.done_i      = 1'b0;
    bus.req_ready_i = 1'b0;
    #1;
    check("ha_count", drained_count_o, cnt(2));

    // ---------------- WORD 0x3000 with 4 cycles of back-pressure ----------------
    load(WORD, 32'h0000_3000, 32'hDEAD_BEEF);
    tick();                    // popped; buffer stays non-empty on purpose
    hold_i = 1'b1;             // must not abort the in-flight store
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("w_valid%0d", i), 32'(bus.req_valid_o), 32'd1);
      check($sformatf("w_addr%0d", i),  bus.req_addr_o,       32'h0000_3000);
      check($sformatf("w_data%0d", i),  bus.req_data_o,       32'hDEAD_BEEF);
      check($sformatf("w_get%0d", i),   32'(sb_get_o),        32'd0);
      tick();
    end
    check("w_wmask", 32'(bus.req_wmask_o), 32'hF);
    bus.req_ready_i = 1'b1;
    tick();
    bus.req_ready_i = 1'b0;
    #1;
    check("w_wait_get",   32'(sb_get_o),        32'd0);
    check("w_wait_valid", 32'(bus.req_valid_o), 32'd0);
    check("w_wait_busy",  32'(busy_o),          32'd1);
    sb_empty_i = 1'b1;
    bus.done_i = 1'b1;
    tick();
    bus.done_i = 1'b0;
    #1;
    check("w_idle",  32'(busy_o),     32'd0);
    check("w_count", drained_count_o, cnt(3));

    // ---------------- hold then flush ----------------
    load(BYTE, 32'h0000_4000, 32'h0000_0055);
    #1;
    check("h_get0",     32'(sb_get_o),  32'd0);
    check("h_drained0", 32'(drained_o), 32'd0);
    tick();
    #1;
    check("h_get1",  32'(sb_get_o), 32'd0);
    check("h_busy1", 32'(busy_o),   32'd0);
    flush_i = 1'b1;
    #1;
    check("f_get", 32'(sb_get_o), 32'd1);
    tick();
    flush_i    = 1'b0;
    sb_empty_i = 1'b1;
    #1;
    check("f_valid", 32'(bus.req_valid_o), 32'd1);
    check("f_wmask", 32'(bus.req_wmask_o), 32'h1);
    check("f_data",  bus.req_data_o,       32'h0000_0055);
    bus.req_ready_i = 1'b1;
    tick();
    bus.req_ready_i = 1'b0;
    bus.done_i      = 1'b1;
    tick();
    bus.done_i = 1'b0;
    hold_i     = 1'b0;
    #1;
    check("f_drained", 32'(drained_o),  32'd1);
    check("f_count",   drained_count_o, cnt(4));

    // ---------------- reset while in WAIT ----------------
    load(WORD, 32'h0000_5000, 32'h1122_3344);
    bus.req_ready_i = 1'b1;
    tick();
    sb_empty_i = 1'b1;
    tick();
    bus.req_ready_i = 1'b0;
    #1;
    check("r_wait_busy", 32'(busy_o), 32'd1);
    reset_n_i  = 1'b0;
    sb_empty_i = 1'b0;          // entry present: must not be popped in reset
    #1;
    check("r_get_in_rst", 32'(sb_get_o), 32'd0);
    tick();
    #1;
    check("r_busy",   32'(busy_o),          32'd0);
    check("r_valid",  32'(bus.req_valid_o), 32'd0);
    check("r_addr",   bus.req_addr_o,       32'd0);
    check("r_data",   bus.req_data_o,       32'd0);
    check("r_wmask",  32'(bus.req_wmask_o), 32'd0);
    check("r_get",    32'(sb_get_o),        32'd0);
    check("r_count",  drained_count_o,      32'd0);
    reset_n_i  = 1'b1;
    sb_empty_i = 1'b1;
    bus.done_i = 1'b1;          // late completion of the abandoned store
    tick();
    bus.done_i = 1'b0;
    #1;
    check("r_late_count", drained_count_o, 32'd0);
    check("r_late_busy",  32'(busy_o),     32'd0);

    // ---------------- three back-to-back WORD stores ----------------
    load(WORD, 32'h0000_6000, 32'hA5A5_0000);
    bus.req_ready_i = 1'b1;
    bus.done_i      = 1'b1;
    for (int i = 0; i < 40 && pop_cyc.size() < 3; i++) begin
      #1;
      if (sb_get_o) pop_cyc.push_back(i);
      tick();
      if (pop_cyc.size() > 0 && pop_cyc[pop_cyc.size()-1] == i) begin
        sb_addr_i = sb_addr_i + 32'd4;
        sb_data_i = sb_data_i + 32'd1;
        if (pop_cyc.size() == 3) sb_empty_i = 1'b1;
      end
    end
    check("bb_pops", 32'(pop_cyc.size()), 32'd3);
    if (pop_cyc.size() == 3) begin
      check("bb_gap01", 32'(pop_cyc[1] - pop_cyc[0] >= 3), 32'd1);
      check("bb_gap12", 32'(pop_cyc[2] - pop_cyc[1] >= 3), 32'd1);
    end
    #1;
    check("bb_last_addr", bus.req_addr_o, 32'h0000_6008);
    check("bb_last_data", bus.req_data_o, 32'hA5A5_0002);
    tick();
    tick();
    bus.req_ready_i = 1'b0;
    bus.done_i      = 1'b0;
    #1;
    check("bb_busy",    32'(busy_o),     32'd0);
    check("bb_drained", 32'(drained_o),  32'd1);
    check("bb_count",   drained_count_o, cnt(3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
